// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with EPC, eret return, branch redirect and a stall-safe pending-redirect buffer.
// Optional ERET_RETURN_PLUS4_EN: eret resumes at epc + STEP instead of epc.
module pc_redirect_unit #(
  parameter int                WIDTH        = 32,
  parameter int                STEP         = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             exc_bd,
  input  logic             eret,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic [WIDTH-1:0] epc_out,
  output logic             flush,
  output logic             pend_valid
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_eret_q, pend_eret_d;
  logic [WIDTH-1:0] eret_target;

`ifdef ERET_RETURN_PLUS4_EN
  assign eret_target = epc_q + STEP_W;
`else
  assign eret_target = epc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      pend_target_q <= '0;
      pend_eret_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_target_q <= pend_target_d;
      pend_eret_q   <= pend_eret_d;
    end
  end

  // Priority: exception > buffered redirect release > eret > branch > stall > sequential.
  always_comb begin
    state_d       = RUN;
    pc_d          = pc_q + STEP_W;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
    pend_eret_d   = pend_eret_q;

    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      epc_d   = exc_bd ? (exc_pc - STEP_W) : exc_pc;
      state_d = FLUSH;
    end else if (state_q == PEND && !stall) begin
      pc_d    = pend_target_q;
      state_d = pend_eret_q ? FLUSH : RUN;
    end else if (eret) begin
      if (stall) begin
        pc_d          = pc_q;
        pend_target_d = eret_target;
        pend_eret_d   = 1'b1;
        state_d       = PEND;
      end else begin
        pc_d    = eret_target;
        state_d = FLUSH;
      end
    end else if (br_valid) begin
      if (stall) begin
        pc_d          = pc_q;
        pend_target_d = br_target;
        pend_eret_d   = 1'b0;
        state_d       = PEND;
      end else begin
        pc_d = br_target;
      end
    end else if (stall) begin
      // A stall during FLUSH still ends the pulse after one cycle.
      pc_d    = pc_q;
      state_d = (state_q == PEND) ? PEND : RUN;
    end
  end

  assign pc_out      = pc_q;
  assign pc_next_seq = pc_q + STEP_W;
  assign epc_out     = epc_q;
  assign flush       = (state_q == FLUSH);
  assign pend_valid  = (state_q == PEND);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed, table-driven bench for pc_redirect_unit; expected values are hand-computed.
// Honours ERET_RETURN_PLUS4_EN when computing eret return addresses.
module tb_pc_redirect_unit;

  localparam int WIDTH = 32;

`ifdef ERET_RETURN_PLUS4_EN
  localparam logic [31:0] ERET_ADJ = 32'd4;
`else
  localparam logic [31:0] ERET_ADJ = 32'd0;
`endif

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             exc_req;
  logic [WIDTH-1:0] exc_pc;
  logic             exc_bd;
  logic             eret;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] epc_out;
  logic             flush;
  logic             pend_valid;

  int total_checks;
  int passed_checks;

  typedef struct {
    logic        stall;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_flush;
    logic        exp_pend;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  pc_redirect_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .exc_req     (exc_req),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .eret        (eret),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .pc_out      (pc_out),
    .pc_next_seq (pc_next_seq),
    .epc_out     (epc_out),
    .flush       (flush),
    .pend_valid  (pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic ex, input logic [31:0] epcin,
                              input logic bd, input logic er, input logic bv,
                              input logic [31:0] bt, input logic [31:0] ep,
                              input logic [31:0] ee, input logic ef, input logic epn);
    vec_t v;
    v.stall = st; v.exc_req = ex; v.exc_pc = epcin; v.exc_bd = bd;
    v.eret = er; v.br_valid = bv; v.br_target = bt;
    v.exp_pc = ep; v.exp_epc = ee; v.exp_flush = ef; v.exp_pend = epn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic st, input logic ex, input logic [31:0] epcin,
                               input logic bd, input logic er, input logic bv,
                               input logic [31:0] bt);
    stall = st; exc_req = ex; exc_pc = epcin; exc_bd = bd;
    eret = er; br_valid = bv; br_target = bt;
    @(posedge clk);
    #1;
    stall = 1'b0; exc_req = 1'b0; eret = 1'b0; br_valid = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] ep, input logic [31:0] ee,
                          input logic ef, input logic epn);
    checkOutput({tag, ".pc"}, pc_out, ep);
    checkOutput({tag, ".epc"}, epc_out, ee);
    checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, ef});
    checkOutput({tag, ".pend"}, {31'd0, pend_valid}, {31'd0, epn});
  endtask

  logic [31:0] r1, r2;

  initial begin
    total_checks = 0;
    passed_checks = 0;
    rst_n = 1'b0;
    stall = 1'b0; exc_req = 1'b0; exc_pc = '0; exc_bd = 1'b0;
    eret = 1'b0; br_valid = 1'b0; br_target = '0;

    r1 = 32'h3004 + ERET_ADJ;
    r2 = 32'h4180 + ERET_ADJ;
    //           st ex exc_pc      bd er bv br_target     exp_pc           exp_epc       f  p
    vecs[0]  = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h3004,        32'h0,        0, 0);
    vecs[1]  = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h3008,        32'h0,        0, 0);
    vecs[2]  = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h300C,        32'h0,        0, 0);
    vecs[3]  = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h3010,        32'h0,        0, 0);
    vecs[4]  = mk(0, 1, 32'h3008,  1, 0, 0, 32'h0,     32'h4180,        32'h3004,     1, 0);
    vecs[5]  = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h4184,        32'h3004,     0, 0);
    vecs[6]  = mk(1, 0, 32'h0,     0, 1, 0, 32'h0,     32'h4184,        32'h3004,     0, 1);
    vecs[7]  = mk(1, 0, 32'h0,     0, 0, 0, 32'h0,     32'h4184,        32'h3004,     0, 1);
    vecs[8]  = mk(1, 0, 32'h0,     0, 0, 0, 32'h0,     32'h4184,        32'h3004,     0, 1);
    vecs[9]  = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     r1,              32'h3004,     1, 0);
    vecs[10] = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     r1 + 32'd4,      32'h3004,     0, 0);
    vecs[11] = mk(1, 0, 32'h0,     0, 0, 1, 32'h3100,  r1 + 32'd4,      32'h3004,     0, 1);
    vecs[12] = mk(1, 0, 32'h0,     0, 0, 1, 32'h3200,  r1 + 32'd4,      32'h3004,     0, 1);
    vecs[13] = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h3200,        32'h3004,     0, 0);
    vecs[14] = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h3204,        32'h3004,     0, 0);
    vecs[15] = mk(0, 1, 32'h3204,  0, 0, 0, 32'h0,     32'h4180,        32'h3204,     1, 0);
    vecs[16] = mk(0, 1, 32'h4180,  0, 0, 0, 32'h0,     32'h4180,        32'h4180,     1, 0);
    vecs[17] = mk(0, 0, 32'h0,     0, 0, 0, 32'h0,     32'h4184,        32'h4180,     0, 0);
    vecs[18] = mk(0, 0, 32'h0,     0, 1, 0, 32'h0,     r2,              32'h4180,     1, 0);
    vecs[19] = mk(0, 0, 32'h0,     0, 0, 1, 32'h5000,  32'h5000,        32'h4180,     0, 0);

    #12;
    checkAll("reset", 32'h3000, 32'h0, 1'b0, 1'b0);
    checkOutput("reset.next_seq", pc_next_seq, 32'h3004);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].exc_req, vecs[i].exc_pc, vecs[i].exc_bd,
                    vecs[i].eret, vecs[i].br_valid, vecs[i].br_target);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_epc,
               vecs[i].exp_flush, vecs[i].exp_pend);
    end

    // Exception beats a pending entry plus a simultaneous eret and branch under stall.
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 32'h6000);
    checkAll("simul.pend", 32'h5000, 32'h4180, 1'b0, 1'b1);
    applyStimulus(1, 1, 32'h5000, 0, 1, 1, 32'h6100);
    checkAll("simul.exc", 32'h4180, 32'h5000, 1'b1, 1'b0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
    checkAll("simul.after", 32'h4184, 32'h5000, 1'b0, 1'b0);

    // Wrap-around of the sequential increment.
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC);
    checkOutput("wrap.pc", pc_out, 32'hFFFF_FFFC);
    checkOutput("wrap.next_seq", pc_next_seq, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("wrap.pc_after", pc_out, 32'h0);

    // Asynchronous reset while a redirect is pending.
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 32'h7000);
    checkAll("areset.pend", 32'h0, 32'h5000, 1'b0, 1'b1);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("areset.now", 32'h3000, 32'h0, 1'b0, 1'b0);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
    checkAll("areset.run", 32'h3004, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised fetch-stage PC register with built-in EPC, for the pipelined MIPS core.
- Generalises the combinational next-PC/eret select into a clocked unit with:
  - reset vector and exception vector,
  - EPC capture with branch-delay adjustment,
  - eret return,
  - branch/jump redirect,
  - stall hold, plus a pending-redirect buffer that preserves redirects arriving during a stall,
  - a one-cycle pipeline flush pulse.
- Feeds IF-stage instruction memory. Receives redirect/exception requests from D/M stages and stall from the hazard unit.

Parameters:
- WIDTH, 32, PC/EPC/target width in bits.
- STEP, 4, sequential increment and branch-delay adjustment (bytes).
- RESET_VECTOR, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception entry.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; requests other than exceptions are buffered.
- exc_req  in  1  exception/interrupt entry request (single-cycle pulse).
- exc_pc  in  WIDTH  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction sits in a branch delay slot.
- eret  in  1  eret decoded in D stage (single-cycle pulse).
- br_valid  in  1  branch/jump taken.
- br_target  in  WIDTH  branch/jump target.
- pc_out  out  WIDTH  current fetch PC (registered).
- pc_next_seq  out  WIDTH  pc_out + STEP (combinational, wraps modulo 2^WIDTH).
- epc_out  out  WIDTH  current EPC register.
- flush  out  1  registered; one-cycle pulse to clear IF/ID after exception entry or eret.
- pend_valid  out  1  a redirect is buffered awaiting stall release.

Behaviour:
Reset (rst_n=0, asynchronous):
- pc_out = RESET_VECTOR, epc_out = 0, flush = 0, pend_valid = 0, state = RUN.
- Mid-operation reset discards any pending redirect and any flush in progress.

Per-cycle priority, highest first:
1. exc_req
   - pc <= EXC_VECTOR.
   - epc <= exc_bd ? exc_pc - STEP : exc_pc.
   - Clears the pending buffer. Next cycle flush = 1.
   - Stall is ignored.
   - eret or br_valid in the same cycle is dropped.
2. pending buffer valid and stall = 0
   - pc <= pend_target, pend_valid <= 0.
   - If the buffered item is an eret, next cycle flush = 1.
3. eret
   - Target = epc (see Optional Feature).
   - stall = 0: pc <= target, next cycle flush = 1.
   - stall = 1: buffer target with kind = ERET, pc holds.
4. br_valid
   - stall = 0: pc <= br_target.
   - stall = 1: buffer br_target, pc holds.
5. stall = 1: pc holds.
6. Otherwise: pc <= pc + STEP, wrapping modulo 2^WIDTH.

Pending buffer:
- Single entry holding {target, kind}.
- A new eret or branch arriving while the buffer is occupied and stall = 1 overwrites it (later request wins).
- The eret target is sampled from epc at capture time, not at release.
- If stall = 0, a pending entry is applied first and a simultaneous new eret or br_valid is dropped. The hazard unit guarantees this case does not occur.

FSM:
- RUN: normal operation.
  - Exception entry → FLUSH.
  - eret applied → FLUSH.
  - Buffer captured → PEND.
- PEND:
  - stall still 1 → stay.
  - stall falls → apply buffer → RUN, or FLUSH if the buffered item was an eret.
  - exc_req → FLUSH.
- FLUSH: flush = 1 for exactly one cycle, then → RUN.
  - A further exc_req while in FLUSH is taken normally and re-enters FLUSH.
- pend_valid = 1 exactly when state = PEND.

Arithmetic:
- All adds and subtracts are WIDTH bits; carry is discarded.
- Targets are not alignment-checked.

Optional Feature:
Macro ERET_RETURN_PLUS4_EN.
- Defined: eret target = epc + STEP, i.e. resume after the faulting instruction. Used for software-completed traps.
- Undefined: eret target = epc, i.e. re-execute the faulting instruction.
- Either way, epc_out shows the raw EPC register.

Test Plan:
- Reset, then 3 free cycles → pc_out sequence 0x3000, 0x3004, 0x3008, 0x300C; flush = 0.
- At pc = 0x3010, exc_req with exc_pc = 0x3008, exc_bd = 1 → next pc 0x4180, epc_out 0x3004, flush = 1 for one cycle only.
- With epc = 0x3004, eret while stall = 1 for 3 cycles → pc holds and pend_valid = 1. When stall releases: pc = 0x3004, or 0x3008 with ERET_RETURN_PLUS4_EN; flush pulses once.
- Stall = 1; br_valid target 0x3100, then br_valid target 0x3200 → after release pc = 0x3200, no flush.
- exc_req, eret and br_valid in the same cycle, with stall = 1 and a pending entry → pc = 0x4180, pending cleared, eret and branch ignored.
- pc = 0xFFFFFFFC (forced via br_target), no stall → next pc 0x00000000. Assert rst_n low mid-PEND → pc 0x3000, pend_valid = 0 immediately, without waiting for a clock edge.
